// File: rtl/eth_tx_framer_pkg.sv
// Shared Ethernet TX framing types and constants.
// The VLAN tag size is only used when ETH_TX_VLAN_EN is defined.
package eth_tx_framer_pkg;

  typedef enum logic [2:0] {IDLE, LEN, HDR, PAY, PAD} eth_tx_state_t;

  localparam int unsigned LEN_W              = 11;
  localparam int unsigned WCNT_W             = 10;
  localparam int unsigned ETH_HDR_BYTES      = 14;
  localparam int unsigned ETH_VLAN_TAG_BYTES = 4;
  localparam int unsigned ETH_MIN_FRAME      = 60;
  localparam int unsigned ETH_MAX_PAYLOAD    = 1500;
  localparam logic [15:0] ETH_TPID_VLAN      = 16'h8100;
  localparam logic [15:0] ETHERTYPE_IPV4     = 16'h0800;
  localparam logic [15:0] ETHERTYPE_ARP      = 16'h0806;

endpackage

// File: rtl/byte_to_word_packer.sv
// 8-to-16 little-endian packer; flush marks the current byte as the last one,
// so an odd trailing byte becomes a word with a zero high byte.
module byte_to_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        flush,
  input  logic        word_ready,
  output logic        in_ready_c,
  output logic [15:0] word_c,
  output logic        word_valid_c
);

  logic       have_low;
  logic [7:0] low_byte;
  logic       take_c;

  // A byte that completes a word may only be taken when the word can be handed off.
  always_comb begin
    in_ready_c   = en && (word_ready || (!have_low && !flush));
    take_c       = in_valid && in_ready_c;
    word_valid_c = take_c && (have_low || flush);
    word_c       = have_low ? {in_data, low_byte} : {8'h00, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_low <= 1'b0;
      low_byte <= 8'h00;
    end else if (clear) begin
      have_low <= 1'b0;
    end else if (take_c) begin
      if (word_valid_c) begin
        have_low <= 1'b0;
      end else begin
        have_low <= 1'b1;
        low_byte <= in_data;
      end
    end
  end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: length first, then header, payload and zero padding as 16-bit words.
// Define ETH_TX_VLAN_EN to insert an 802.1Q tag (VLAN_TCI) after the source MAC.
module eth_tx_framer
  import eth_tx_framer_pkg::*;
#(
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h0011_2233_4455,
  parameter int unsigned MAX_PAYLOAD = ETH_MAX_PAYLOAD,
  parameter int unsigned MIN_FRAME   = ETH_MIN_FRAME
`ifdef ETH_TX_VLAN_EN
  ,
  parameter logic [15:0] VLAN_TCI    = 16'h0001
`endif
) (
  input  logic        clk100,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] ethertype,
  input  logic [10:0] pay_len,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [10:0] len_out,
  output logic        len_valid,
  input  logic        len_ready,
  output logic [15:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        err
);

`ifdef ETH_TX_VLAN_EN
  localparam int unsigned HDR_BYTES = ETH_HDR_BYTES + ETH_VLAN_TAG_BYTES;
`else
  localparam int unsigned HDR_BYTES = ETH_HDR_BYTES;
`endif
  localparam int unsigned HDR_BITS  = 8 * HDR_BYTES;
  localparam int unsigned HDR_WORDS = HDR_BYTES / 2;

  eth_tx_state_t       state;
  logic [15:0]         type_q;
  logic [LEN_W-1:0]    pay_len_q;
  logic [LEN_W-1:0]    byte_cnt;
  logic [WCNT_W-1:0]   word_cnt;
  logic [WCNT_W-1:0]   nwords;

  logic [LEN_W-1:0]    frame_len_c;
  logic [HDR_BITS-1:0] hdr_vec_c;
  logic [HDR_BITS-1:0] hdr_shift_c;
  logic [15:0]         hdr_word_c;
  logic                pk_en_c;
  logic                pk_last_c;
  logic                pk_in_ready_c;
  logic [15:0]         pk_word_c;
  logic                pk_word_valid_c;

  always_comb begin
    frame_len_c = LEN_W'(HDR_BYTES) + pay_len;
    if (frame_len_c < LEN_W'(MIN_FRAME)) frame_len_c = LEN_W'(MIN_FRAME);
  end

  // Header as a wire-ordered byte vector; word k takes bytes 2k (low) and 2k+1 (high).
  always_comb begin
`ifdef ETH_TX_VLAN_EN
    hdr_vec_c = {DST_MAC, SRC_MAC, ETH_TPID_VLAN, VLAN_TCI, type_q};
`else
    hdr_vec_c = {DST_MAC, SRC_MAC, type_q};
`endif
    hdr_shift_c = hdr_vec_c << {word_cnt[3:0], 4'b0000};
    hdr_word_c  = {hdr_shift_c[HDR_BITS-9 -: 8], hdr_shift_c[HDR_BITS-1 -: 8]};
  end

  always_comb begin
    pk_en_c   = (state == PAY);
    pk_last_c = (byte_cnt == pay_len_q - LEN_W'(1));
    in_ready  = pk_in_ready_c;
  end

  byte_to_word_packer u_packer (
    .clk          (clk100),
    .rst_n        (rst_n),
    .clear        (state == IDLE),
    .en           (pk_en_c),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .flush        (pk_last_c),
    .word_ready   (!out_valid),
    .in_ready_c   (pk_in_ready_c),
    .word_c       (pk_word_c),
    .word_valid_c (pk_word_valid_c)
  );

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      type_q    <= 16'h0000;
      pay_len_q <= '0;
      byte_cnt  <= '0;
      word_cnt  <= '0;
      nwords    <= '0;
      len_out   <= '0;
      len_valid <= 1'b0;
      out_word  <= 16'h0000;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      // Word handshake retires the output; the last word ends the frame.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        if (out_last) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (pay_len > LEN_W'(MAX_PAYLOAD)) begin
              err <= 1'b1;
            end else begin
              type_q    <= ethertype;
              pay_len_q <= pay_len;
              len_out   <= frame_len_c;
              nwords    <= WCNT_W'((frame_len_c + LEN_W'(1)) >> 1);
              byte_cnt  <= '0;
              word_cnt  <= '0;
              len_valid <= 1'b1;
              busy      <= 1'b1;
              state     <= LEN;
            end
          end
        end
        LEN: begin
          if (len_ready) begin
            len_valid <= 1'b0;
            state     <= HDR;
          end
        end
        HDR: begin
          if (!out_valid || out_ready) begin
            out_word  <= hdr_word_c;
            out_valid <= 1'b1;
            word_cnt  <= word_cnt + WCNT_W'(1);
            if (word_cnt == WCNT_W'(HDR_WORDS - 1)) begin
              state <= (pay_len_q == '0) ? PAD : PAY;
            end
          end
        end
        PAY: begin
          if (in_valid && pk_in_ready_c) begin
            byte_cnt <= byte_cnt + LEN_W'(1);
            if (pk_last_c) state <= PAD;
          end
          if (pk_word_valid_c) begin
            out_word  <= pk_word_c;
            out_valid <= 1'b1;
            out_last  <= (word_cnt == nwords - WCNT_W'(1));
            word_cnt  <= word_cnt + WCNT_W'(1);
          end
        end
        PAD: begin
          // Also serves as the wait for the final handshake once all words are issued.
          if ((word_cnt != nwords) && (!out_valid || out_ready)) begin
            out_word  <= 16'h0000;
            out_valid <= 1'b1;
            out_last  <= (word_cnt == nwords - WCNT_W'(1));
            word_cnt  <= word_cnt + WCNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: stimulus pushes expected length/words, a monitor pops and compares.
module tb_eth_tx_framer;
  import eth_tx_framer_pkg::*;

  localparam logic [47:0] DST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC = 48'h0011_2233_4455;
`ifdef ETH_TX_VLAN_EN
  localparam logic [15:0] TCI = 16'h0001;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] ethertype;
  logic [10:0] pay_len;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] len_out;
  logic        len_valid;
  logic        len_ready;
  logic [15:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        err;

  eth_tx_framer dut (
    .clk100    (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ethertype (ethertype),
    .pay_len   (pay_len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .len_out   (len_out),
    .len_valid (len_valid),
    .len_ready (len_ready),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [16:0] word_q[$];
  logic [10:0] len_q[$];
  logic [15:0] got_words[$];
  int          got_cyc[$];
  bit          rand_rdy = 1'b0;
  bit          abort = 1'b0;
  bit          len_taken = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_word = 16'h0000;
  int          words_seen = 0;
  int          last_count = 0;
  int          last_len = 0;
  int          bytes_in = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event occurred but was not allowed", name);
  endtask

  // Reference frame as a plain byte list, padded, then paired low-byte-first.
  task automatic expect_frame(input logic [15:0] et, input int plen, input logic [7:0] seed);
    logic [7:0] b[$];
    int nw;
    for (int i = 0; i < 6; i++) b.push_back(DST[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) b.push_back(SRC[47-8*i -: 8]);
`ifdef ETH_TX_VLAN_EN
    b.push_back(ETH_TPID_VLAN[15:8]);
    b.push_back(ETH_TPID_VLAN[7:0]);
    b.push_back(TCI[15:8]);
    b.push_back(TCI[7:0]);
`endif
    b.push_back(et[15:8]);
    b.push_back(et[7:0]);
    for (int i = 0; i < plen; i++) b.push_back(8'(seed + 8'(i)));
    while (b.size() < 60) b.push_back(8'h00);
    len_q.push_back(11'(b.size()));
    if (b.size() % 2 == 1) b.push_back(8'h00);
    nw = b.size() / 2;
    for (int w = 0; w < nw; w++) word_q.push_back({(w == nw - 1), b[2*w+1], b[2*w]});
  endtask

  // Monitor: compares every length and word handshake against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (len_valid && out_valid) flag("len_and_word_together");
        if (len_valid && len_ready) begin
          if (len_q.size() == 0) flag("len_unexpected");
          else check("len_out", 32'(len_out), 32'(len_q.pop_front()));
          last_len = int'(len_out);
          len_taken = 1'b1;
        end
        if (in_valid && in_ready) bytes_in++;
        if (out_valid) begin
          if (prev_stall) check("word_stable", 32'(out_word), 32'(prev_word));
          if (out_ready) begin
            if (!len_taken) flag("word_before_len");
            if (word_q.size() == 0) begin
              flag("word_unexpected");
            end else begin
              logic [16:0] e;
              e = word_q.pop_front();
              check("out_word", 32'(out_word), 32'(e[15:0]));
              check("out_last", 32'(out_last), 32'(e[16]));
            end
            got_words.push_back(out_word);
            got_cyc.push_back(cyc);
            words_seen++;
            if (out_last) begin
              last_count = words_seen;
              words_seen = 0;
              len_taken = 1'b0;
            end
          end
          prev_stall = !out_ready;
          prev_word = out_word;
        end else begin
          prev_stall = 1'b0;
        end
      end
    end
  end

  // Downstream sinks: always ready or randomly stalling.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) begin
        out_ready = 1'($urandom_range(0, 1));
        len_ready = ($urandom_range(0, 3) == 0);
      end else begin
        out_ready = 1'b1;
        len_ready = 1'b1;
      end
    end
  end

  task automatic request(input logic [15:0] et, input int plen);
    @(posedge clk);
    #1;
    start = 1'b1;
    ethertype = et;
    pay_len = 11'(plen);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_bytes(input int n, input logic [7:0] seed, input bit gaps);
    for (int i = 0; i < n; i++) begin
      bit acc;
      int budget;
      acc = 1'b0;
      budget = 200;
      while (!acc && budget > 0) begin
        @(posedge clk);
        #1;
        if (abort) begin
          in_valid = 1'b0;
          return;
        end
        in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_data = 8'(seed + 8'(i));
        @(negedge clk);
        acc = in_valid && in_ready;
        budget--;
      end
      if (!acc) begin
        flag("feed_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((word_q.size() != 0 || busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) flag("frame_timeout");
    check("queues_drained", 32'(word_q.size() + len_q.size()), 32'd0);
  endtask

  task automatic run_frame(input logic [15:0] et, input int plen, input logic [7:0] seed,
                           input bit gaps, input bit rnd);
    rand_rdy = rnd;
    got_words.delete();
    got_cyc.delete();
    expect_frame(et, plen, seed);
    request(et, plen);
    if (plen > 0) send_bytes(plen, seed, gaps);
    wait_done();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_len_valid"}, 32'(len_valid), 32'd0);
    check({tag, "_len_out"}, 32'(len_out), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_word"}, 32'(out_word), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ethertype = 16'h0000;
    pay_len = '0;
    in_data = 8'h00;
    in_valid = 1'b0;
    out_ready = 1'b1;
    len_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Minimum-size payload, back-to-back sinks.
    run_frame(ETHERTYPE_IPV4, 46, 8'h00, 1'b0, 1'b0);
    check("t46_len", 32'(last_len), 32'd60);
    check("t46_count", 32'(last_count), 32'd30);
    check("t46_w0", 32'(got_words[0]), 32'h0000FFFF);
    check("t46_w3", 32'(got_words[3]), 32'h00001100);
    check("t46_w5", 32'(got_words[5]), 32'h00005544);
    check("t46_w6", 32'(got_words[6]), 32'h00000008);
    check("t46_w7", 32'(got_words[7]), 32'h00000100);
    check("t46_hdr_rate", 32'(got_cyc[6] - got_cyc[0]), 32'd6);
    check("t46_pay_rate", 32'(got_cyc[9] - got_cyc[7]), 32'd4);

    // Empty payload: header then 23 pad words.
    run_frame(ETHERTYPE_ARP, 0, 8'h00, 1'b0, 1'b0);
    check("t0_len", 32'(last_len), 32'd60);
    check("t0_count", 32'(last_count), 32'd30);
    check("t0_w6", 32'(got_words[6]), 32'h00000608);
    check("t0_w29", 32'(got_words[29]), 32'h00000000);

    // Odd length above minimum.
    run_frame(ETHERTYPE_IPV4, 47, 8'h00, 1'b0, 1'b0);
    check("t47_len", 32'(last_len), 32'd61);
    check("t47_count", 32'(last_count), 32'd31);
    check("t47_last", 32'(got_words[30]), 32'h0000002E);

    // Oversize request is rejected with a one-cycle err.
    begin
      bit saw;
      saw = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b1;
      pay_len = 11'd1501;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("rej_err_pulse", 32'(err), 32'd1);
      check("rej_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check("rej_err_one_cycle", 32'(err), 32'd0);
      repeat (20) begin
        @(negedge clk);
        if (len_valid || busy) saw = 1'b1;
      end
      check("rej_no_frame", 32'(saw), 32'd0);
    end

    // Stalls on both sides plus a start pulse while busy.
    rand_rdy = 1'b1;
    got_words.delete();
    got_cyc.delete();
    expect_frame(16'h88B5, 100, 8'h30);
    request(16'h88B5, 100);
    fork
      send_bytes(100, 8'h30, 1'b1);
      begin
        repeat (40) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        start = 1'b1;
        pay_len = 11'd5;
        ethertype = 16'h1234;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    join
    wait_done();
    check("t100_len", 32'(last_len), 32'd114);
    check("t100_count", 32'(last_count), 32'd57);
    rand_rdy = 1'b0;
    repeat (10) @(posedge clk);
    check("t100_no_extra", 32'(len_q.size() + word_q.size()), 32'd0);

    // Asynchronous reset in the middle of the payload.
    expect_frame(ETHERTYPE_IPV4, 100, 8'h00);
    bytes_in = 0;
    request(ETHERTYPE_IPV4, 100);
    fork
      send_bytes(100, 8'h00, 1'b0);
      begin
        int t;
        t = 0;
        while (bytes_in < 20 && t < 500) begin
          @(negedge clk);
          t++;
        end
        if (t >= 500) flag("rst_wait_timeout");
        #2;
        rst_n = 1'b0;
        abort = 1'b1;
        #1;
        check_all_zero("midrst");
      end
    join
    word_q.delete();
    len_q.delete();
    len_taken = 1'b0;
    words_seen = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    abort = 1'b0;
    run_frame(ETHERTYPE_IPV4, 10, 8'h50, 1'b0, 1'b0);
    check("t10_len", 32'(last_len), 32'd60);
    check("t10_count", 32'(last_count), 32'd30);
    check("t10_w7", 32'(got_words[7]), 32'h00005150);
    check("t10_w11", 32'(got_words[11]), 32'h00005958);
    check("t10_w12", 32'(got_words[12]), 32'h00000000);

    // Largest accepted payload.
    run_frame(ETHERTYPE_IPV4, 1500, 8'h07, 1'b0, 1'b0);
    check("tmax_len", 32'(last_len), 32'd1514);
    check("tmax_count", 32'(last_count), 32'd757);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
